// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter sequencing shared accesses to one synchronous single-port RAM.
// Each access runs grant (IDLE) -> ACC (RAM edge) -> CAP (read data capture), then a one-cycle ack.
module ram_arbiter #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    // Handshake: a port raises req with addr/we/wdata valid; they are sampled only on the
    // grant edge. ack pulses for exactly one cycle when the access is done (rdata valid then
    // for reads). A request seen together with its own ack is not eligible for a new grant.
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic          busy,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic [1:0]    dbg_state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] CAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          ptr_q, ptr_d;     // 0: A has priority, 1: B has priority
    logic          win_q, win_d;     // 0: A owns the access, 1: B
    logic          rd_q, rd_d;
    logic          cs_q, cs_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] din_q, din_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic [DW-1:0] rdata_a_q, rdata_a_d;
    logic [DW-1:0] rdata_b_q, rdata_b_d;
    logic          busy_q, busy_d;

    logic elig_a, elig_b, pick_b;

    always_comb begin
        elig_a = req_a & ~ack_a_q;
        elig_b = req_b & ~ack_b_q;
        pick_b = elig_b & (~elig_a | ptr_q);

        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        rd_d      = rd_q;
        cs_d      = cs_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        din_d     = din_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;

        case (state_q)
            IDLE: begin
                if (elig_a || elig_b) begin
                    win_d   = pick_b;
                    ptr_d   = ~pick_b;
                    addr_d  = pick_b ? addr_b : addr_a;
                    din_d   = pick_b ? wdata_b : wdata_a;
                    rw_d    = pick_b ? ~we_b : ~we_a;
                    rd_d    = pick_b ? ~we_b : ~we_a;
                    cs_d    = 1'b1;
                    state_d = ACC;
                end
            end
            ACC: begin
                cs_d    = 1'b0;
                rw_d    = 1'b1;
                state_d = CAP;
            end
            CAP: begin
                if (win_q) begin
                    ack_b_d = 1'b1;
                    if (rd_q) rdata_b_d = ram_dout;
                end else begin
                    ack_a_d = 1'b1;
                    if (rd_q) rdata_a_d = ram_dout;
                end
                state_d = IDLE;
            end
            default: begin
                cs_d    = 1'b0;
                rw_d    = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            rd_q      <= 1'b0;
            cs_q      <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            rd_q      <= rd_d;
            cs_q      <= cs_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            busy_q    <= busy_d;
        end
    end

    assign ram_cs      = cs_q;
    assign ram_rw      = rw_q;
    assign ram_addr    = addr_q;
    assign ram_din     = din_q;
    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign rdata_a     = rdata_a_q;
    assign rdata_b     = rdata_b_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester arbiter and sequencer for the generic synchronous single-port RAM (cs, rw with 1 = read and 0 = write, registered read data one cycle after the access edge).
- Port A is the Simplez CPU; port B is the serial loader/monitor. Both share one RAM instance.
- Each access is a three-state sequence: grant, access, capture.
- Contention is resolved round-robin. Each requester gets a one-cycle ack with its read data.

Parameters:
- AW, 9, address width in bits; must match the RAM's AW.
- DW, 12, data width in bits; must match the RAM's DW.

Ports:
- clk  in  1  global clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req_a  in  1  port A request; hold high until ack_a
- we_a  in  1  port A write enable: 1 = write, 0 = read
- addr_a  in  AW  port A address
- wdata_a  in  DW  port A write data
- ack_a  out  1  port A completion pulse, one cycle
- rdata_a  out  DW  port A read data; valid while ack_a=1 after a read
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as the port A signals, for port B
- busy  out  1  high when the state is not IDLE
- ram_cs  out  1  RAM chip select
- ram_rw  out  1  RAM rw: 1 = read, 0 = write
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM registered read data

Behaviour:
- Reset, asynchronous on rstn=0:
  - state goes to IDLE.
  - ram_cs=0, ram_rw=1, ram_addr=0, ram_din=0.
  - ack_a=ack_b=0, rdata_a=rdata_b=0, busy=0.
  - Round-robin pointer is set to "A has priority".
- All outputs are registered. There is no combinational path from any req to any RAM pin.

State machine (states IDLE, ACC, CAP):
- IDLE:
  - A requester is eligible when its req=1 and its ack=0 in the same cycle. This blocks re-grant of a request that is being acknowledged this cycle.
  - If no requester is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the port named by the pointer.
  - On the granting edge:
    - latch the winner's addr, wdata and we into ram_addr, ram_din and ram_rw (ram_rw = ~we);
    - set ram_cs=1;
    - record the winner;
    - flip the pointer to the other port;
    - go to ACC.
- ACC (1 cycle):
  - ram_cs=1 with stable addr, data and rw. The RAM performs the access on the edge that leaves ACC.
  - On that edge: ram_cs goes to 0, ram_rw goes to 1, go to CAP.
- CAP (1 cycle):
  - ram_dout is valid during this cycle if the access was a read.
  - On the edge that leaves CAP:
    - set the winner's ack to 1;
    - if the access was a read, load the winner's rdata from ram_dout;
    - go to IDLE.
  - The winner's ack falls on the next edge.

Latency and throughput:
- With req sampled high at edge e0, ack is high in the cycle following edge e2: three cycles from request to ack.
- Throughput is at most one access per three cycles. Back-to-back accesses alternate ports when both request.

Read data and writes:
- rdata_x holds its last read value until the next read for that port.
- A write does not change rdata_x.

Request handling:
- addr, we and wdata are sampled only at the grant edge. They may change afterwards.
- If req drops after the grant, the access still completes and ack still pulses.
- If req drops before the grant, no access happens.
- The non-winning request stays pending. It is served next, because the pointer already points to it.

Boundary conditions:
- Address wrap: no address arithmetic is performed; addresses 0 and 2^AW-1 pass through unchanged.
- ram_cs is high only in ACC, so no write can occur in any other state.
- Reset asserted mid-operation (ACC or CAP): the sequence aborts, ram_cs drops immediately, no ack is issued and the pointer returns to "A has priority". If reset lands in ACC, the RAM contents at that address are undefined.

Test Plan:
- Write then read, single port: after reset, A writes addr=0x005 data=0xABC, then reads 0x005. Required: ram_cs high exactly one cycle per access, ram_rw=0 then 1, ack_a three cycles after each req, rdata_a=0xABC, ack_b never high.
- Simultaneous first request: A and B both request reads on the same edge right after reset. Required: A is served first, B is granted on the first IDLE cycle after ack_a, busy stays 1 except for one IDLE cycle between the two accesses.
- Round-robin fairness: A and B hold req continuously with 6 accesses each queued. Required: grants alternate A,B,A,B…; neither port waits more than 6 cycles between acks.
- No double grant: A holds req through its ack cycle. Required: exactly one RAM access per ack; the second access is granted only if req_a is still high after ack_a falls.
- Address and data extremes: B writes addr=0x1FF data=0xFFF and addr=0x000 data=0x000, then reads both back. Required: rdata_b=0xFFF and then 0x000; ram_addr is exactly 0x1FF and 0x000.
- Reset mid-access: assert rstn=0 during ACC of an A write. Required: ram_cs=0 asynchronously, all acks 0, state IDLE; after release, a simultaneous A and B request serves A first.
